// File: rtl/sobel_pkg.sv
// Shared types, error-bit indices and geometry helpers for the sobel frame sequencer.
package sobel_pkg;

    localparam int unsigned PIXEL_W  = 32;
    localparam int unsigned FRAMES_W = 16;
    localparam int unsigned ERR_W    = 4;

    localparam int unsigned ERR_EARLY_LAST   = 0;
    localparam int unsigned ERR_MISSING_LAST = 1;
    localparam int unsigned ERR_OUT_FRAMING  = 2;
    localparam int unsigned ERR_TIMEOUT      = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int unsigned pixel_count(input int unsigned w, input int unsigned h);
        return w * h;
    endfunction

    // Beat counters hold 0..N-1; keep at least one bit for degenerate 1-pixel frames.
    function automatic int unsigned cnt_width(input int unsigned w, input int unsigned h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Source/pipeline stream signals seen by the frame sequencer.
interface sobel_frame_ctrl_if;
    import sobel_pkg::*;

    logic               src_valid_i;
    logic               src_ready_o;
    logic [PIXEL_W-1:0] src_pixel_i;
    logic               src_last_i;
    logic               pipe_valid_o;
    logic               pipe_ready_i;
    logic [PIXEL_W-1:0] pipe_pixel_o;
    logic               pipe_out_valid_i;
    logic               pipe_out_ready_i;
    logic               pipe_last_i;

    // Environment side: drives the source and the pipeline handshakes.
    modport master (
        output src_valid_i, src_pixel_i, src_last_i, pipe_ready_i,
               pipe_out_valid_i, pipe_out_ready_i, pipe_last_i,
        input  src_ready_o, pipe_valid_o, pipe_pixel_o
    );

    // Sequencer side.
    modport slave (
        input  src_valid_i, src_pixel_i, src_last_i, pipe_ready_i,
               pipe_out_valid_i, pipe_out_ready_i, pipe_last_i,
        output src_ready_o, pipe_valid_o, pipe_pixel_o
    );

endinterface

// File: rtl/sobel_beat_counter.sv
// Clear/enable beat counter wrapping at N_P-1, with a combinational terminal flag.
module sobel_beat_counter #(
    parameter int unsigned N_P = 12,
    parameter int unsigned W_P = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic last_c
);

    logic [W_P-1:0] cnt;

    assign last_c = (cnt == W_P'(N_P - 1));

    always_ff @(posedge clk_i) begin
        if (reset_i || clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= last_c ? '0 : cnt + W_P'(1);
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer: admits one WIDTH_P*HEIGHT_P frame, waits for the pipeline's last beat, flags framing errors.
// Optional drain watchdog enabled by defining SOBEL_CTRL_TIMEOUT_EN.
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int unsigned WIDTH_P   = 640,
    parameter int unsigned HEIGHT_P  = 480,
    parameter int unsigned TIMEOUT_P = 65536
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                continuous_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [FRAMES_W-1:0] frames_o,
    output logic [ERR_W-1:0]    err_o,
    sobel_frame_ctrl_if.slave   stream
);

    localparam int unsigned N     = pixel_count(WIDTH_P, HEIGHT_P);
    localparam int unsigned CNT_W = cnt_width(WIDTH_P, HEIGHT_P);

    state_e           state;
    state_e           state_next;
    logic             start_acc;
    logic             cnt_clr;
    logic             src_acc;
    logic             out_beat;
    logic             out_last_beat;
    logic             in_last;
    logic             out_last;
    logic             frame_done;
    logic             timeout;
    logic             wd_expired;
    logic [ERR_W-1:0] err_set;

    assign busy_o              = (state != IDLE);
    assign stream.pipe_pixel_o = stream.src_pixel_i;

    // Handshake qualifiers are built from the state and raw inputs, not from our own ready/valid.
    assign src_acc       = (state == FEED) && stream.src_valid_i && stream.pipe_ready_i;
    assign out_beat      = busy_o && stream.pipe_out_valid_i && stream.pipe_out_ready_i;
    assign out_last_beat = out_beat && stream.pipe_last_i;

    sobel_beat_counter #(.N_P(N), .W_P(CNT_W)) u_in_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (cnt_clr),
        .en_i    (src_acc),
        .last_c  (in_last)
    );

    sobel_beat_counter #(.N_P(N), .W_P(CNT_W)) u_out_cnt (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clr_i   (cnt_clr || out_last_beat),
        .en_i    (out_beat),
        .last_c  (out_last)
    );

`ifdef SOBEL_CTRL_TIMEOUT_EN
    localparam int unsigned WD_W = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;

    logic [WD_W-1:0] wd_cnt;

    // Counts idle DRAIN cycles since entry or the most recent output beat.
    always_ff @(posedge clk_i) begin
        if (reset_i || (state != DRAIN) || out_beat) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_expired = (state == DRAIN) && !out_beat && (wd_cnt == WD_W'(TIMEOUT_P - 1));
`else
    logic unused_timeout;

    assign unused_timeout = |TIMEOUT_P;
    assign wd_expired     = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next          = state;
        start_acc           = 1'b0;
        cnt_clr             = 1'b0;
        frame_done          = 1'b0;
        timeout             = 1'b0;
        stream.src_ready_o  = 1'b0;
        stream.pipe_valid_o = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    start_acc  = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = FEED;
                end
            end
            FEED: begin
                stream.src_ready_o  = stream.pipe_ready_i;
                stream.pipe_valid_o = stream.src_valid_i;
                if (src_acc && in_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_last_beat) begin
                    frame_done = 1'b1;
                    if (continuous_i) begin
                        cnt_clr    = 1'b1;
                        state_next = FEED;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (wd_expired) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Framing checks; an output last during FEED is always a framing error.
    always_comb begin
        err_set                   = '0;
        err_set[ERR_EARLY_LAST]   = src_acc && stream.src_last_i && !in_last;
        err_set[ERR_MISSING_LAST] = src_acc && in_last && !stream.src_last_i;
        err_set[ERR_OUT_FRAMING]  = out_last_beat && (!out_last || (state == FEED));
        err_set[ERR_TIMEOUT]      = timeout;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            done_o   <= 1'b0;
            frames_o <= '0;
            err_o    <= '0;
        end else begin
            done_o <= frame_done;
            if (frame_done) begin
                frames_o <= frames_o + FRAMES_W'(1);
            end
            if (start_acc) begin
                err_o <= '0;
            end else begin
                err_o <= err_o | err_set;
            end
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl with a 4x3 frame (N=12); the bench plays source and pipeline.
module tb_sobel_frame_ctrl;

    localparam int unsigned N = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        continuous;
    logic        busy;
    logic        done;
    logic [15:0] frames;
    logic [3:0]  err;

    int checks   = 0;
    int failures = 0;

    sobel_frame_ctrl_if bus ();

    sobel_frame_ctrl #(
        .WIDTH_P   (4),
        .HEIGHT_P  (3),
        .TIMEOUT_P (20)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .continuous_i (continuous),
        .busy_o       (busy),
        .done_o       (done),
        .frames_o     (frames),
        .err_o        (err),
        .stream       (bus)
    );

    always #5 clk = ~clk;

    task automatic start_frame();
        start = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL start_idle busy got=%b exp=0", busy); end
        @(negedge clk);
        start = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || err !== 4'h0) begin
            failures++; $display("FAIL start_feed busy/err got=%b/%h exp=1/0", busy, err);
        end
    endtask

    task automatic feed_frame(input int nbeats, input int last_at, input bit toggle);
        int k = 0;
        int cyc = 0;
        logic rdy;
        logic [31:0] pix;
        while (k < nbeats && cyc < 200) begin
            pix = 32'hA500_0000 + 32'(k);
            rdy = toggle ? (cyc % 2 == 0) : 1'b1;
            bus.src_valid_i  = 1'b1;
            bus.src_pixel_i  = pix;
            bus.src_last_i   = (k + 1 == last_at);
            bus.pipe_ready_i = rdy;
            #1;
            checks++;
            if (bus.src_ready_o !== rdy || bus.pipe_valid_o !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL feed_gate beat=%0d ready/valid/busy got=%b/%b/%b exp=%b/1/1",
                         k, bus.src_ready_o, bus.pipe_valid_o, busy, rdy);
            end
            if (rdy) begin
                checks++;
                if (bus.pipe_pixel_o !== pix) begin
                    failures++; $display("FAIL feed_pixel beat=%0d got=%h exp=%h", k, bus.pipe_pixel_o, pix);
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.src_last_i = 1'b0;
        checks++;
        if (k != nbeats) begin failures++; $display("FAIL feed_count got=%0d exp=%0d", k, nbeats); end
        if (nbeats == N) begin
            bus.pipe_ready_i = 1'b1;
            #1;
            checks++;
            if (bus.src_ready_o !== 1'b0 || bus.pipe_valid_o !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL feed_closed ready/valid/busy got=%b/%b/%b exp=0/0/1",
                         bus.src_ready_o, bus.pipe_valid_o, busy);
            end
        end
        bus.src_valid_i = 1'b0;
    endtask

    task automatic drain_frame(input int nout, input int last_at);
        for (int j = 0; j < nout; j++) begin
            bus.pipe_out_valid_i = 1'b1;
            bus.pipe_out_ready_i = 1'b1;
            bus.pipe_last_i      = (j + 1 == last_at);
            #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                failures++; $display("FAIL drain_busy beat=%0d done/busy got=%b/%b exp=0/1", j, done, busy);
            end
            @(negedge clk);
        end
        bus.pipe_out_valid_i = 1'b0;
        bus.pipe_last_i      = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.src_valid_i  = 1'b1;
        bus.pipe_ready_i = 1'b1;
        bus.src_pixel_i  = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || frames !== 16'h0 || err !== 4'h0) begin
            failures++; $display("FAIL reset_regs busy/done/frames/err got=%b/%b/%h/%h exp=0/0/0/0",
                                 busy, done, frames, err);
        end
        checks++;
        if (bus.src_ready_o !== 1'b0 || bus.pipe_valid_o !== 1'b0) begin
            failures++; $display("FAIL reset_gate ready/valid got=%b/%b exp=0/0", bus.src_ready_o, bus.pipe_valid_o);
        end
        checks++;
        if (bus.pipe_pixel_o !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL reset_passthru got=%h exp=deadbeef", bus.pipe_pixel_o);
        end
        bus.src_valid_i = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_done(input string tag, input logic [15:0] exp_frames,
                              input logic [3:0] exp_err, input logic exp_busy);
        #1;
        checks++;
        if (done !== 1'b1 || frames !== exp_frames || err !== exp_err || busy !== exp_busy) begin
            failures++;
            $display("FAIL %s done/frames/err/busy got=%b/%0d/%b/%b exp=1/%0d/%b/%b",
                     tag, done, frames, err, busy, exp_frames, exp_err, exp_busy);
        end
    endtask

    task automatic test_basic();
        start_frame();
        feed_frame(12, 12, 1'b0);
        drain_frame(12, 12);
        check_done("basic_done", 16'd1, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b exp=0", done); end
    endtask

    task automatic test_backpressure();
        start_frame();
        feed_frame(12, 12, 1'b1);
        start = 1'b1;
        drain_frame(12, 12);
        start = 1'b0;
        check_done("bp_done_start_ignored", 16'd2, 4'b0000, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL bp_not_queued busy got=%b exp=0", busy); end
    endtask

    task automatic test_early_last();
        start_frame();
        feed_frame(12, 5, 1'b0);
        checks++;
        if (err !== 4'b0011) begin failures++; $display("FAIL early_err got=%b exp=0011", err); end
        drain_frame(12, 12);
        check_done("early_done", 16'd3, 4'b0011, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_continuous();
        continuous = 1'b1;
        start_frame();
        feed_frame(12, 5, 1'b0);
        drain_frame(12, 12);
        check_done("cont_f1", 16'd4, 4'b0011, 1'b1);
        feed_frame(12, 12, 1'b0);
        drain_frame(12, 12);
        check_done("cont_f2", 16'd5, 4'b0011, 1'b1);
        feed_frame(12, 12, 1'b0);
        continuous = 1'b0;
        drain_frame(12, 12);
        check_done("cont_f3", 16'd6, 4'b0011, 1'b0);
        @(negedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL cont_pulse got=%b exp=0", done); end
    endtask

    task automatic test_out_framing();
        start_frame();
        feed_frame(12, 12, 1'b0);
        drain_frame(5, 5);
        check_done("outframe_done", 16'd7, 4'b0100, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        start_frame();
        feed_frame(6, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || frames !== 16'h0 || err !== 4'h0 || bus.src_ready_o !== 1'b0) begin
            failures++; $display("FAIL midreset busy/frames/err/ready got=%b/%0d/%b/%b exp=0/0/0000/0",
                                 busy, frames, err, bus.src_ready_o);
        end
        reset = 1'b0;
        @(negedge clk);
        start_frame();
        feed_frame(12, 12, 1'b0);
        drain_frame(12, 12);
        check_done("midreset_clean", 16'd1, 4'b0000, 1'b0);
        @(negedge clk);
    endtask

`ifdef SOBEL_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        start_frame();
        feed_frame(12, 12, 1'b0);
        drain_frame(3, 0);
        for (int i = 1; i < 20; i++) @(negedge clk);
        #1;
        checks++;
        if (err[3] !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL timeout_early err3/busy got=%b/%b exp=0/1", err[3], busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (err[3] !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || frames !== 16'd1) begin
            failures++; $display("FAIL timeout_fire err3/busy/done/frames got=%b/%b/%b/%0d exp=1/0/0/1",
                                 err[3], busy, done, frames);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        reset                = 1'b1;
        start                = 1'b0;
        continuous           = 1'b0;
        bus.src_valid_i      = 1'b0;
        bus.src_pixel_i      = '0;
        bus.src_last_i       = 1'b0;
        bus.pipe_ready_i     = 1'b0;
        bus.pipe_out_valid_i = 1'b0;
        bus.pipe_out_ready_i = 1'b0;
        bus.pipe_last_i      = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_early_last();
        test_continuous();
        test_out_framing();
        test_reset_mid();
`ifdef SOBEL_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
